// File: rtl/pipe_ctrl_chain_if.sv
// Instruction-issue and commit bundle between ID, the pipeline register chain and writeback.
// master = ID/writeback side, slave = chain.
interface pipe_ctrl_chain_if #(
  parameter int DATA_W = 96,
  parameter int RIDX_W = 5
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [RIDX_W-1:0] in_rd;
  logic              in_rd_wr;
  logic [RIDX_W-1:0] in_rs1;
  logic              in_rs1_used;
  logic [RIDX_W-1:0] in_rs2;
  logic              in_rs2_used;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [RIDX_W-1:0] out_rd;
  logic              out_rd_wr;

  modport master (
    output in_valid, in_data, in_rd, in_rd_wr, in_rs1, in_rs1_used, in_rs2, in_rs2_used,
    input  in_ready, out_valid, out_data, out_rd, out_rd_wr
  );

  modport slave (
    input  in_valid, in_data, in_rd, in_rd_wr, in_rs1, in_rs1_used, in_rs2, in_rs2_used,
    output in_ready, out_valid, out_data, out_rd, out_rd_wr
  );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// In-order DEPTH-stage register chain with stall, branch flush and RAW interlock; input reaches commit after DEPTH cycles.
// Backpressure: in_ready drops while stage 0 is held, a RAW hazard is present, or a flush is resolving.
module pipe_ctrl_chain #(
  parameter int DEPTH      = 3,
  parameter int DATA_W     = 96,
  parameter int RIDX_W     = 5,
  parameter int HAZ_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_chain_if.slave bus,
  input  logic [DEPTH-1:0] stall_i,
  input  logic             flush_i,
  input  logic [2:0]       flush_stage,
  output logic [DEPTH-1:0] stage_valid,
  output logic             hazard_o,
  output logic [31:0]      hazard_cnt
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  rd_wr_q, rd_wr_d;
  logic [RIDX_W-1:0] rd_q   [DEPTH];
  logic [RIDX_W-1:0] rd_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [31:0]       hazard_cnt_q, hazard_cnt_d;

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] kill;
  logic             in_ready;
  logic             accept;

  // A hold anywhere propagates to every younger stage.
  always_comb begin : hold_calc
    logic [DEPTH-1:0] h;
    h = '0;
    h[DEPTH-1] = stall_i[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      h[i] = stall_i[i] | h[i+1];
    end
    hold = h;
  end

  // Stages younger than the resolving stage carry wrong-path work.
  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = flush_i && (int'(flush_stage) < DEPTH) && (i < int'(flush_stage));
    end
  end

  always_comb begin : hazard_calc
    logic haz;
    haz = 1'b0;
    for (int j = 0; j < HAZ_STAGES; j++) begin
      if (valid_q[j] && rd_wr_q[j] && (rd_q[j] != '0) &&
          ((bus.in_rs1_used && (bus.in_rs1 == rd_q[j])) ||
           (bus.in_rs2_used && (bus.in_rs2 == rd_q[j])))) begin
        haz = 1'b1;
      end
    end
    hazard_o = bus.in_valid & haz;
  end

  assign in_ready     = ~rst & ~hold[0] & ~hazard_o & ~flush_i;
  assign accept       = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;

  always_comb begin
    valid_d      = valid_q;
    rd_wr_d      = rd_wr_q;
    rd_d         = rd_q;
    data_d       = data_q;
    hazard_cnt_d = hazard_cnt_q;

    if (!hold[0]) begin
      valid_d[0] = accept;
      rd_wr_d[0] = accept & bus.in_rd_wr;
      rd_d[0]    = bus.in_rd;
      data_d[0]  = bus.in_data;
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (!hold[i]) begin
        if (hold[i-1]) begin
          valid_d[i] = 1'b0;
          rd_wr_d[i] = 1'b0;
        end else begin
          valid_d[i] = valid_q[i-1] & ~kill[i-1];
          rd_wr_d[i] = rd_wr_q[i-1] & ~kill[i-1];
          rd_d[i]    = rd_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
        rd_wr_d[i] = 1'b0;
      end
    end

    if (hazard_o) begin
      hazard_cnt_d = hazard_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      rd_wr_q      <= '0;
      hazard_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      rd_wr_q      <= rd_wr_d;
      hazard_cnt_q <= hazard_cnt_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
    end
  end

  assign stage_valid   = valid_q;
  assign hazard_cnt    = hazard_cnt_q;
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.out_rd    = rd_q[DEPTH-1];
  assign bus.out_rd_wr = valid_q[DEPTH-1] & rd_wr_q[DEPTH-1];

endmodule
